// File: rtl/ir_a2d_sequencer_pkg.sv
// Shared types for the IR line-sensor sweep sequencer: FSM states, emitter slots
// and the A2D channel assignment of each emitter pair.
package ir_a2d_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CNV_L,
        ST_WAIT_L,
        ST_CNV_R,
        ST_WAIT_R,
        ST_DONE,
        ST_HOLD
    } state_e;

    typedef enum logic [1:0] {
        SLOT_IN,
        SLOT_MID,
        SLOT_OUT
    } slot_e;

    localparam logic [2:0] CH_IN_L  = 3'd1;
    localparam logic [2:0] CH_IN_R  = 3'd0;
    localparam logic [2:0] CH_MID_L = 3'd4;
    localparam logic [2:0] CH_MID_R = 3'd2;
    localparam logic [2:0] CH_OUT_L = 3'd3;
    localparam logic [2:0] CH_OUT_R = 3'd7;

    function automatic logic [2:0] chanFor(slot_e slot, logic right);
        logic [2:0] ch;
        case (slot)
            SLOT_IN:  ch = right ? CH_IN_R  : CH_IN_L;
            SLOT_MID: ch = right ? CH_MID_R : CH_MID_L;
            SLOT_OUT: ch = right ? CH_OUT_R : CH_OUT_L;
            default:  ch = 3'd0;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/ir_a2d_sequencer_if.sv
// Request/complete handshake between the sweep sequencer (master) and the
// SPI A2D front end (slave).
interface ir_a2d_sequencer_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
    modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface

// File: rtl/ir_a2d_sequencer_pwm8.sv
// ir_pwm8: free-running 8-bit PWM generator for the IR emitter enables.
// Only exists when IR_PWM_EN is defined; otherwise the enables are held solid.
`ifdef IR_PWM_EN
module ir_pwm8 #(
    parameter logic [7:0] DUTY = 8'h8C
) (
    input  logic clk,
    input  logic rst_n,
    output logic pwm_o
);

    logic [7:0] pwm_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
        end
    end

    assign pwm_o = (pwm_cnt_q < DUTY);

endmodule
`endif

// File: rtl/ir_a2d_sequencer.sv
// Sweeps the three IR emitter pairs, converting left/right readings of each
// through the A2D handshake; IR_PWM_EN selects PWM-modulated emitter enables.
module ir_a2d_sequencer
    import ir_a2d_sequencer_pkg::*;
#(
    parameter int SETTLE = 2048,
    parameter int PERIOD = 20000,
    parameter int TMO    = 1024
`ifdef IR_PWM_EN
    ,
    parameter logic [7:0] DUTY = 8'h8C
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    ir_a2d_sequencer_if.master a2d,
    output logic               IR_in_en,
    output logic               IR_mid_en,
    output logic               IR_out_en,
    output logic [11:0]        lft_in,
    output logic [11:0]        rht_in,
    output logic [11:0]        lft_mid,
    output logic [11:0]        rht_mid,
    output logic [11:0]        lft_out,
    output logic [11:0]        rht_out,
    output logic               sample_rdy,
    output logic               a2d_err
);

    localparam logic [15:0] SETTLE_M1 = 16'(SETTLE - 1);
    localparam logic [15:0] PERIOD_M1 = 16'(PERIOD - 1);
    localparam logic [15:0] TMO_M1    = 16'(TMO - 1);

    state_e      state_q, state_d;
    slot_e       slot_q, slot_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] period_q, period_d;
    logic        err_q, err_d;
    logic        latchLeft, latchRight;
    logic        slotOn, pwmBit, irOn;
    logic [11:0] lft_in_q, rht_in_q, lft_mid_q, rht_mid_q, lft_out_q, rht_out_q;

`ifdef IR_PWM_EN
    ir_pwm8 #(.DUTY(DUTY)) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm_o (pwmBit)
    );
`else
    assign pwmBit = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            slot_q   <= SLOT_IN;
            cnt_q    <= '0;
            period_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            err_q    <= err_d;
        end
    end

    // cnt_q is shared: settle time in SETTLE, cycles since the request in WAIT_*
    // (preloaded to 1 so the request cycle counts towards the timeout).
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        cnt_d      = cnt_q;
        period_d   = (period_q == 16'hFFFF) ? period_q : period_q + 16'd1;
        err_d      = err_q;
        latchLeft  = 1'b0;
        latchRight = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d  = ST_SETTLE;
                    slot_d   = SLOT_IN;
                    period_d = '0;
                    cnt_d    = '0;
                end
            end
            ST_SETTLE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == SETTLE_M1) begin
                    state_d = ST_CNV_L;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_CNV_L, ST_CNV_R: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = (state_q == ST_CNV_L) ? ST_WAIT_L : ST_WAIT_R;
                    cnt_d   = 16'd1;
                end
            end
            ST_WAIT_L, ST_WAIT_R: begin
                if (a2d.cnv_cmplt || (cnt_q == TMO_M1)) begin
                    latchLeft  = a2d.cnv_cmplt && (state_q == ST_WAIT_L);
                    latchRight = a2d.cnv_cmplt && (state_q == ST_WAIT_R);
                    if (!a2d.cnv_cmplt) begin
                        err_d = 1'b1;
                    end
                    if (!en) begin
                        state_d = ST_IDLE;
                    end else if (state_q == ST_WAIT_L) begin
                        state_d = ST_CNV_R;
                    end else if (slot_q == SLOT_OUT) begin
                        state_d = ST_DONE;
                    end else begin
                        slot_d  = (slot_q == SLOT_IN) ? SLOT_MID : SLOT_OUT;
                        cnt_d   = '0;
                        state_d = ST_SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = en ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (period_q >= PERIOD_M1) begin
                    state_d  = ST_SETTLE;
                    slot_d   = SLOT_IN;
                    period_d = '0;
                    cnt_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lft_in_q  <= '0;
            rht_in_q  <= '0;
            lft_mid_q <= '0;
            rht_mid_q <= '0;
            lft_out_q <= '0;
            rht_out_q <= '0;
        end else begin
            case (slot_q)
                SLOT_IN: begin
                    if (latchLeft)  lft_in_q <= a2d.res;
                    if (latchRight) rht_in_q <= a2d.res;
                end
                SLOT_MID: begin
                    if (latchLeft)  lft_mid_q <= a2d.res;
                    if (latchRight) rht_mid_q <= a2d.res;
                end
                SLOT_OUT: begin
                    if (latchLeft)  lft_out_q <= a2d.res;
                    if (latchRight) rht_out_q <= a2d.res;
                end
                default: ;
            endcase
        end
    end

    // Gating with en makes the emitters and any pending request drop the
    // moment the sweep is disabled, without waiting for the state to move.
    always_comb begin
        slotOn       = en && (state_q inside {ST_SETTLE, ST_CNV_L, ST_WAIT_L, ST_CNV_R, ST_WAIT_R});
        irOn         = slotOn && pwmBit;
        IR_in_en     = irOn && (slot_q == SLOT_IN);
        IR_mid_en    = irOn && (slot_q == SLOT_MID);
        IR_out_en    = irOn && (slot_q == SLOT_OUT);
        a2d.strt_cnv = en && ((state_q == ST_CNV_L) || (state_q == ST_CNV_R));
        a2d.chnnl    = 3'd0;
        if ((state_q == ST_CNV_L) || (state_q == ST_WAIT_L)) begin
            a2d.chnnl = chanFor(slot_q, 1'b0);
        end else if ((state_q == ST_CNV_R) || (state_q == ST_WAIT_R)) begin
            a2d.chnnl = chanFor(slot_q, 1'b1);
        end
    end

    assign sample_rdy = (state_q == ST_DONE);
    assign a2d_err    = err_q;
    assign lft_in     = lft_in_q;
    assign rht_in     = rht_in_q;
    assign lft_mid    = lft_mid_q;
    assign rht_mid    = rht_mid_q;
    assign lft_out    = lft_out_q;
    assign rht_out    = rht_out_q;

endmodule
